// File: rtl/mux_seven_seg.sv
// mux_seven_seg: time-multiplexed seven-segment scanner with a
// double-buffered digit register, guard-banded slots and zero blanking.
module mux_seven_seg #(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 50000,
  parameter int GUARD_CYC  = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    pending
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [1:0] S_OFF   = 2'd0;
  localparam logic [1:0] S_GUARD = 2'd1;
  localparam logic [1:0] S_SHOW  = 2'd2;

  localparam logic [CW-1:0] CNT_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [6:0]    SEG_OFF    = 7'h7F;

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DW-1:0]         shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic [DW-1:0]         disp_q, disp_d;
  logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
  logic                  pending_q, pending_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_start;

  logic [3:0]            nib;
  logic                  dp_bit;
  logic                  blank;
  logic                  zero_hi;
  logic [NUM_DIGITS-1:0] lz;

  // {a,b,c,d,e,f,g} active-low glyphs for hex digits
  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    s = SEG_OFF;
    case (n)
      4'h0: s = 7'h01;
      4'h1: s = 7'h4F;
      4'h2: s = 7'h12;
      4'h3: s = 7'h06;
      4'h4: s = 7'h4C;
      4'h5: s = 7'h24;
      4'h6: s = 7'h20;
      4'h7: s = 7'h0F;
      4'h8: s = 7'h00;
      4'h9: s = 7'h0C;
      4'hA: s = 7'h08;
      4'hB: s = 7'h60;
      4'hC: s = 7'h31;
      4'hD: s = 7'h42;
      4'hE: s = 7'h30;
      4'hF: s = 7'h38;
    endcase
    return s;
  endfunction

  // scan sequencer: guard then show per slot, frame start on wrap or wake
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    frame_start = 1'b0;
    if (!enable) begin
      state_d = S_OFF;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        S_OFF: begin
          state_d     = S_GUARD;
          cnt_d       = '0;
          idx_d       = '0;
          frame_start = 1'b1;
        end
        S_GUARD: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == GUARD_LAST) begin
            state_d = S_SHOW;
          end
        end
        S_SHOW: begin
          if (cnt_q == CNT_LAST) begin
            state_d = S_GUARD;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              idx_d       = '0;
              frame_start = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = S_OFF;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // shadow takes every load; display only refreshes at frame start
  always_comb begin
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    disp_d      = disp_q;
    disp_dp_d   = disp_dp_q;
    pending_d   = pending_q;
    if (load) begin
      shadow_d    = data;
      shadow_dp_d = dp_in;
    end
    if (frame_start) begin
      disp_d    = load ? data : shadow_q;
      disp_dp_d = load ? dp_in : shadow_dp_q;
      pending_d = 1'b0;
    end else if (load) begin
      pending_d = 1'b1;
    end
  end

  // next-cycle drive for the digit selected by the state being entered
  always_comb begin
    an_d    = '1;
    seg_d   = SEG_OFF;
    dp_d    = 1'b1;
    nib     = 4'h0;
    dp_bit  = 1'b0;
    blank   = 1'b0;
    zero_hi = 1'b1;
    lz      = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_hi = zero_hi & (disp_d[4*i +: 4] == 4'h0);
      lz[i]   = zero_hi & (i > 0);
    end
    if (state_d == S_SHOW) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx_d == IW'(i)) begin
          nib     = disp_d[4*i +: 4];
          dp_bit  = disp_dp_d[i];
          blank   = blank_lz & lz[i];
          an_d[i] = 1'b0;
        end
      end
      seg_d = blank ? SEG_OFF : decode(nib);
      dp_d  = ~dp_bit;
    end
  end

  // state and registered outputs, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_OFF;
      cnt_q       <= '0;
      idx_q       <= '0;
      shadow_q    <= '0;
      shadow_dp_q <= '0;
      disp_q      <= '0;
      disp_dp_q   <= '0;
      pending_q   <= 1'b0;
      seg_q       <= SEG_OFF;
      dp_q        <= 1'b1;
      an_q        <= '1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      shadow_dp_q <= shadow_dp_d;
      disp_q      <= disp_d;
      disp_dp_q   <= disp_dp_d;
      pending_q   <= pending_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      an_q        <= an_d;
    end
  end

  assign seg     = seg_q;
  assign dp      = dp_q;
  assign an      = an_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_mux_seven_seg.sv
// tb_mux_seven_seg: frame-time model plus directed literal checks
// for the seven-segment scanner at ND=4, CLK_DIV=8, GUARD=2.
module tb_mux_seven_seg;

  localparam int ND = 4;
  localparam int CD = 8;
  localparam int GC = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          enable = 1'b0;
  logic          load = 1'b0;
  logic [15:0]   data = 16'h0;
  logic [3:0]    dp_in = 4'h0;
  logic          blank_lz = 1'b0;
  logic [6:0]    seg;
  logic          dp;
  logic [3:0]    an;
  logic          pending;

  int n_chk = 0;
  int n_pass = 0;
  logic chk_en = 1'b0;

  logic [6:0] tbl [0:15] = '{7'h01, 7'h4F, 7'h12, 7'h06,
                             7'h4C, 7'h24, 7'h20, 7'h0F,
                             7'h00, 7'h0C, 7'h08, 7'h60,
                             7'h31, 7'h42, 7'h30, 7'h38};

  mux_seven_seg #(
    .NUM_DIGITS(ND),
    .CLK_DIV(CD),
    .GUARD_CYC(GC)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .load(load),
    .data(data),
    .dp_in(dp_in),
    .blank_lz(blank_lz),
    .seg(seg),
    .dp(dp),
    .an(an),
    .pending(pending)
  );

  always #5 clk = ~clk;

  // model: time since frame start, buffered digits
  logic        m_on = 1'b0;
  int          m_t = 0;
  logic [15:0] m_sh = 16'h0;
  logic [3:0]  m_shdp = 4'h0;
  logic [15:0] m_disp = 16'h0;
  logic [3:0]  m_ddp = 4'h0;
  logic        m_pend = 1'b0;
  logic        m_blank = 1'b0;

  logic        n_on;
  int          n_t;
  logic        fs;
  logic [15:0] n_disp;
  logic [3:0]  n_ddp;
  logic        n_pend;

  always_comb begin
    n_on   = m_on;
    n_t    = m_t;
    fs     = 1'b0;
    n_disp = m_disp;
    n_ddp  = m_ddp;
    n_pend = m_pend;
    if (!enable) begin
      n_on = 1'b0;
    end else if (!m_on) begin
      n_on = 1'b1;
      n_t  = 0;
      fs   = 1'b1;
    end else if (m_t == ND * CD - 1) begin
      n_t = 0;
      fs  = 1'b1;
    end else begin
      n_t = m_t + 1;
    end
    if (fs) begin
      n_disp = load ? data : m_sh;
      n_ddp  = load ? dp_in : m_shdp;
      n_pend = 1'b0;
    end else if (load) begin
      n_pend = 1'b1;
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_on    <= 1'b0;
      m_t     <= 0;
      m_sh    <= 16'h0;
      m_shdp  <= 4'h0;
      m_disp  <= 16'h0;
      m_ddp   <= 4'h0;
      m_pend  <= 1'b0;
      m_blank <= 1'b0;
    end else begin
      m_on    <= n_on;
      m_t     <= n_t;
      m_disp  <= n_disp;
      m_ddp   <= n_ddp;
      m_pend  <= n_pend;
      m_blank <= blank_lz;
      if (load) begin
        m_sh   <= data;
        m_shdp <= dp_in;
      end
    end
  end

  // {an, seg, dp} the display must show for the model's current time
  function automatic logic [11:0] expect_out();
    int d;
    logic [15:0] hi;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic e_dp;
    if (!m_on || (m_t % CD) < GC) return {4'hF, 7'h7F, 1'b1};
    d = m_t / CD;
    hi = m_disp >> (4 * d);
    e_an = ~(4'b0001 << d);
    if (m_blank && d > 0 && hi == 16'h0) e_seg = 7'h7F;
    else e_seg = tbl[hi[3:0]];
    e_dp = ~m_ddp[d];
    return {e_an, e_seg, e_dp};
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic lit(input string nm, input logic [3:0] e_an,
                     input logic [6:0] e_seg, input logic e_dp);
    check({nm, ".an"}, 32'(an), 32'(e_an));
    check({nm, ".seg"}, 32'(seg), 32'(e_seg));
    check({nm, ".dp"}, 32'(dp), 32'(e_dp));
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic restart();
    enable = 1'b0;
    cyc(1);
    enable = 1'b1;
    cyc(1);
  endtask

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      logic [11:0] e;
      e = expect_out();
      check("mdl.an", 32'(an), 32'(e[11:8]));
      check("mdl.seg", 32'(seg), 32'(e[7:1]));
      check("mdl.dp", 32'(dp), 32'(e[0]));
      check("mdl.pending", 32'(pending), 32'(m_pend));
    end
  end

  initial begin
    enable = 1'b1;
    load = 1'b1;
    data = 16'hA5A5;
    #2 reset_n = 1'b0;
    #1;
    lit("rst", 4'hF, 7'h7F, 1'b1);
    check("rst.pending", 32'(pending), 32'd0);
    chk_en = 1'b1;
    cyc(2);
    reset_n = 1'b1;
    enable = 1'b0;
    load = 1'b0;

    cyc(1);
    data = 16'h12AF;
    dp_in = 4'b0100;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    enable = 1'b1;
    cyc(1);
    lit("scan.guard", 4'hF, 7'h7F, 1'b1);
    cyc(2);
    lit("scan.d0", 4'hE, 7'h38, 1'b1);
    check("scan.pending", 32'(pending), 32'd0);
    cyc(8);
    lit("scan.d1", 4'hD, 7'h08, 1'b1);
    cyc(8);
    lit("scan.d2", 4'hB, 7'h12, 1'b0);
    cyc(8);
    lit("scan.d3", 4'h7, 7'h4F, 1'b1);
    cyc(8);
    lit("scan.rep", 4'hE, 7'h38, 1'b1);

    data = 16'h0050;
    dp_in = 4'h0;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    blank_lz = 1'b1;
    restart();
    cyc(2);
    lit("blz.d0", 4'hE, 7'h01, 1'b1);
    cyc(8);
    lit("blz.d1", 4'hD, 7'h24, 1'b1);
    cyc(8);
    lit("blz.d2", 4'hB, 7'h7F, 1'b1);
    cyc(8);
    lit("blz.d3", 4'h7, 7'h7F, 1'b1);

    data = 16'h0000;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    restart();
    cyc(2);
    lit("zero.d0", 4'hE, 7'h01, 1'b1);
    cyc(8);
    lit("zero.d1", 4'hD, 7'h7F, 1'b1);
    blank_lz = 1'b0;
    cyc(8);
    lit("nob.d2", 4'hB, 7'h01, 1'b1);
    cyc(8);
    lit("nob.d3", 4'h7, 7'h01, 1'b1);
    cyc(8);
    lit("nob.d0", 4'hE, 7'h01, 1'b1);

    restart();
    cyc(10);
    data = 16'h3333;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    lit("dbuf.d1", 4'hD, 7'h01, 1'b1);
    check("dbuf.pend1", 32'(pending), 32'd1);
    cyc(8);
    lit("dbuf.d2", 4'hB, 7'h01, 1'b1);
    check("dbuf.pend2", 32'(pending), 32'd1);
    cyc(15);
    lit("dbuf.new", 4'hE, 7'h06, 1'b1);
    check("dbuf.pend0", 32'(pending), 32'd0);
    cyc(29);
    data = 16'h9998;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    check("wrap.pend", 32'(pending), 32'd0);
    lit("wrap.guard", 4'hF, 7'h7F, 1'b1);
    cyc(2);
    lit("wrap.d0", 4'hE, 7'h00, 1'b1);

    cyc(16);
    data = 16'h00C7;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    lit("dis.d2", 4'hB, 7'h0C, 1'b1);
    enable = 1'b0;
    cyc(1);
    lit("dis.off", 4'hF, 7'h7F, 1'b1);
    check("dis.pend", 32'(pending), 32'd1);
    enable = 1'b1;
    cyc(1);
    lit("ren.g0", 4'hF, 7'h7F, 1'b1);
    check("ren.pend", 32'(pending), 32'd0);
    cyc(1);
    lit("ren.g1", 4'hF, 7'h7F, 1'b1);
    cyc(1);
    lit("ren.d0", 4'hE, 7'h0F, 1'b1);

    cyc(8);
    lit("ar.d1", 4'hD, 7'h31, 1'b1);
    data = 16'hBEEF;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    check("ar.pend1", 32'(pending), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    lit("ar.off", 4'hF, 7'h7F, 1'b1);
    check("ar.pend0", 32'(pending), 32'd0);
    #1 reset_n = 1'b1;
    cyc(3);
    lit("ar.d0", 4'hE, 7'h01, 1'b1);
    cyc(8);
    lit("ar.d1z", 4'hD, 7'h01, 1'b1);
    check("ar.pendz", 32'(pending), 32'd0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mux_seven_seg.md
MUX_SEVEN_SEG -- requirements
Module: mux_seven_seg

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of scanned digits (legal 1..8).
REQ-002 SHALL have parameter CLK_DIV, default 50000, clocks per digit slot (legal >= 4).
REQ-003 SHALL have parameter GUARD_CYC, default 2, all-off clocks at start of each slot (legal 1..CLK_DIV-2).
REQ-004 SHALL have ports: clk  in  1  sole clock, rising edge; reset_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: enable  in  1  display on; load  in  1  capture strobe; data  in  4*NUM_DIGITS  hex nibbles, nibble 0 = rightmost digit.
REQ-006 SHALL have ports: dp_in  in  NUM_DIGITS  decimal points; blank_lz  in  1  leading-zero blanking enable.
REQ-007 SHALL have ports: seg  out  7  {a,b,c,d,e,f,g}, active-low; dp  out  1  active-low; an  out  NUM_DIGITS  digit enables, active-low; pending  out  1  loaded value not yet displayed.

Function
REQ-008 SHALL hold a shadow register (data, dp_in) written on every clock with load=1; the last load wins.
REQ-009 SHALL hold a display register, copied from shadow only at frame start (see REQ-013, REQ-014).
REQ-010 SHALL implement FSM states OFF, GUARD, SHOW, with slot counter cnt (0..CLK_DIV-1) and digit index idx (0..NUM_DIGITS-1).
REQ-011 OFF: cnt=0, idx=0; on enable=1, go to GUARD.
REQ-012 GUARD: cnt increments each clock; at cnt=GUARD_CYC-1, go to SHOW with cnt incrementing.
REQ-013 SHOW: at cnt=CLK_DIV-1, go to GUARD with cnt=0 and idx=idx+1; idx wraps NUM_DIGITS-1 -> 0, and that wrap is a frame start.
REQ-014 OFF -> GUARD transition SHALL also be a frame start.
REQ-015 enable=0 sampled in any state SHALL force OFF on that edge.
REQ-016 Outputs SHALL be registered and reflect the state entered on the same edge; no combinational path from inputs to outputs.
REQ-017 In OFF and GUARD: an all 1, seg=7'h7F, dp=1.
REQ-018 In SHOW: an[idx]=0 and all other bits 1; seg=decode(display nibble idx); dp=~display_dp[idx].
REQ-019 Decode table {a..g}, hex 0..F SHALL be: 01,4F,12,06,4C,24,20,0F,00,0C,08,60,31,42,30,38.
REQ-020 Leading-zero blanking: with blank_lz=1, digit i>0 whose nibble and all higher nibbles are 0 SHALL drive seg=7'h7F with an still asserted; dp still follows REQ-018; digit 0 is never blanked.
REQ-021 pending SHALL set on any clock with load=1 and clear at frame start.
REQ-022 If load coincides with a frame start, the display register SHALL take the incoming data/dp_in and pending SHALL be 0 after that edge.
REQ-023 A load outside a frame start SHALL NOT change the digits of the frame in progress.

Reset
REQ-024 reset_n=0 SHALL immediately, independent of clk, force state OFF, cnt=0, idx=0, shadow=0, display=0, pending=0, an all 1, seg=7'h7F, dp=1.
REQ-025 Reset asserted mid-frame SHALL discard pending data; after release, operation resumes per REQ-011.

Verification (NUM_DIGITS=4, CLK_DIV=8, GUARD_CYC=2)
REQ-026 Reset with enable=1 and load=1 held -> an=4'hF, seg=7'h7F, dp=1, pending=0 with no clock edge.
REQ-027 load data=16'h12AF, dp_in=4'b0100, then enable=1 -> per slot: 2 clocks all-off, then 6 clocks of: an=4'hE seg=38; an=4'hD seg=08; an=4'hB seg=12 dp=0; an=4'h7 seg=4F; frame repeats every 32 clocks.
REQ-028 data=16'h0050, blank_lz=1 -> digits 3,2 show seg=7'h7F; digit 1 shows seg=24; digit 0 shows seg=01; data=0 -> only digit 0 lit, showing seg=01; blank_lz=0 -> all four digits show seg=01.
REQ-029 load 16'h3333 during digit-1 SHOW -> frame still shows old value, pending=1 until wrap, then digit 0 shows seg=06 and pending=0; load coincident with wrap edge -> new value shows on digit 0 immediately and pending=0.
REQ-030 enable dropped during SHOW of digit 2 -> next edge an=4'hF, seg=7'h7F; re-enable -> 2 GUARD clocks, then digit 0 shows the latest shadow value.
REQ-031 reset_n pulsed low for less than one clock during SHOW -> outputs go off asynchronously, pending=0, display reads 0 after restart.
